// File: rtl/mseq_generator.sv
// Maximal-length sequence generator: run-time order 4..16 Fibonacci LFSR with programmable
// chip length and amplitude, plus chip and period-start strobes for correlation logic.
module mseq_generator #(
  parameter int unsigned OUTPUT_DATA_WIDTH = 16,
  parameter int unsigned DIV_WIDTH         = 16
) (
  input  logic                         MSEQ_clk,
  input  logic                         MSEQ_rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic [4:0]                   cfg_order,
  input  logic [15:0]                  cfg_seed,
  input  logic [DIV_WIDTH-1:0]         cfg_div,
  input  logic [OUTPUT_DATA_WIDTH-1:0] cfg_amp,
  output logic [OUTPUT_DATA_WIDTH-1:0] MSEQ_signal,
  output logic                         mseq_bit,
  output logic                         mseq_valid,
  output logic                         mseq_period_start,
  output logic                         busy
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e                       r_state, w_state_d;
  logic [4:0]                   r_order, w_order_d;
  logic [DIV_WIDTH-1:0]         r_div, w_div_d;
  logic [OUTPUT_DATA_WIDTH-1:0] r_amp, w_amp_d;
  logic [15:0]                  r_seed, w_seed_d;
  logic [15:0]                  r_lfsr, w_lfsr_d;
  logic [DIV_WIDTH-1:0]         r_cnt, w_cnt_d;
  logic [OUTPUT_DATA_WIDTH-1:0] r_signal, w_signal_d;
  logic                         r_bit, w_bit_d;
  logic                         r_valid, w_valid_d;
  logic                         r_ps, w_ps_d;

  logic [4:0]  w_order_clamp;
  logic [15:0] w_new_mask, w_new_top, w_seed_masked, w_seed_load;
  logic [15:0] w_run_mask, w_run_top, w_lfsr_step;
  logic        w_fb, w_chip_end, w_start;

  function automatic logic [15:0] f_mask(input logic [4:0] n);
    logic [16:0] m;
    m = (17'd1 << n) - 17'd1;
    return m[15:0];
  endfunction

  // Bit (t-1) set for every feedback tap t of the order-n polynomial.
  function automatic logic [15:0] f_taps(input logic [4:0] n);
    case (n)
      5'd4:    return 16'h000C;
      5'd5:    return 16'h0014;
      5'd6:    return 16'h0030;
      5'd7:    return 16'h0060;
      5'd8:    return 16'h00B8;
      5'd9:    return 16'h0110;
      5'd10:   return 16'h0240;
      5'd11:   return 16'h0500;
      5'd12:   return 16'h0829;
      5'd13:   return 16'h100D;
      5'd14:   return 16'h2015;
      5'd15:   return 16'h6000;
      5'd16:   return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  always_comb begin
    if (cfg_order < 5'd4)       w_order_clamp = 5'd4;
    else if (cfg_order > 5'd16) w_order_clamp = 5'd16;
    else                        w_order_clamp = cfg_order;
  end

  assign w_new_mask    = f_mask(w_order_clamp);
  assign w_new_top     = w_new_mask & ~(w_new_mask >> 1);
  assign w_seed_masked = cfg_seed & w_new_mask;
  assign w_seed_load   = (w_seed_masked == 16'd0) ? 16'd1 : w_seed_masked;

  assign w_run_mask  = f_mask(r_order);
  assign w_run_top   = w_run_mask & ~(w_run_mask >> 1);
  assign w_fb        = ^(r_lfsr & f_taps(r_order));
  assign w_lfsr_step = {r_lfsr[14:0], w_fb} & w_run_mask;
  assign w_chip_end  = (r_cnt == r_div);
  assign w_start     = start && !stop;

  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) r_state <= StIdle;
    else             r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_start) w_state_d = StRun;
      StRun:   if (stop)    w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Computes the next registered outputs and datapath; every output is a flop.
  always_comb begin
    w_order_d  = r_order;
    w_div_d    = r_div;
    w_amp_d    = r_amp;
    w_seed_d   = r_seed;
    w_lfsr_d   = r_lfsr;
    w_cnt_d    = r_cnt;
    w_signal_d = '0;
    w_bit_d    = 1'b0;
    w_valid_d  = 1'b0;
    w_ps_d     = 1'b0;
    if (stop) begin
      w_cnt_d = '0;
    end else if (start) begin
      w_order_d  = w_order_clamp;
      w_div_d    = cfg_div;
      w_amp_d    = cfg_amp;
      w_seed_d   = w_seed_load;
      w_lfsr_d   = w_seed_load;
      w_cnt_d    = '0;
      w_bit_d    = |(w_seed_load & w_new_top);
      w_signal_d = w_bit_d ? cfg_amp : '0;
      w_valid_d  = 1'b1;
      w_ps_d     = 1'b1;
    end else if (r_state == StRun) begin
      w_bit_d    = r_bit;
      w_signal_d = r_signal;
      if (w_chip_end) begin
        w_cnt_d    = '0;
        w_lfsr_d   = w_lfsr_step;
        w_bit_d    = |(w_lfsr_step & w_run_top);
        w_signal_d = w_bit_d ? r_amp : '0;
        w_valid_d  = 1'b1;
        w_ps_d     = (w_lfsr_step == r_seed);
      end else begin
        w_cnt_d = r_cnt + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge MSEQ_clk or negedge MSEQ_rst_n) begin
    if (!MSEQ_rst_n) begin
      r_order  <= '0;
      r_div    <= '0;
      r_amp    <= '0;
      r_seed   <= '0;
      r_lfsr   <= '0;
      r_cnt    <= '0;
      r_signal <= '0;
      r_bit    <= 1'b0;
      r_valid  <= 1'b0;
      r_ps     <= 1'b0;
    end else begin
      r_order  <= w_order_d;
      r_div    <= w_div_d;
      r_amp    <= w_amp_d;
      r_seed   <= w_seed_d;
      r_lfsr   <= w_lfsr_d;
      r_cnt    <= w_cnt_d;
      r_signal <= w_signal_d;
      r_bit    <= w_bit_d;
      r_valid  <= w_valid_d;
      r_ps     <= w_ps_d;
    end
  end

  assign MSEQ_signal       = r_signal;
  assign mseq_bit          = r_bit;
  assign mseq_valid        = r_valid;
  assign mseq_period_start = r_ps;
  assign busy              = (r_state == StRun);

endmodule

// File: tb/tb_mseq_generator.sv
// Scoreboard bench: each run pushes its expected chips from a reference sequence model; a
// monitor pops one entry per mseq_valid and checks value, period marker, amplitude and spacing.
module tb_mseq_generator;

  logic        clk, rst_n, start, stop;
  logic [4:0]  cfg_order;
  logic [15:0] cfg_seed, cfg_div, cfg_amp;
  logic [15:0] sig;
  logic        mbit, mvalid, mps, busy;

  mseq_generator #(.OUTPUT_DATA_WIDTH(16), .DIV_WIDTH(16)) dut (
    .MSEQ_clk         (clk),
    .MSEQ_rst_n       (rst_n),
    .start            (start),
    .stop             (stop),
    .cfg_order        (cfg_order),
    .cfg_seed         (cfg_seed),
    .cfg_div          (cfg_div),
    .cfg_amp          (cfg_amp),
    .MSEQ_signal      (sig),
    .mseq_bit         (mbit),
    .mseq_valid       (mvalid),
    .mseq_period_start(mps),
    .busy             (busy)
  );

  typedef struct {
    logic        b;
    logic        ps;
    logic [15:0] amp;
    int          gap;
  } chip_t;

  chip_t q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Feedback straight from the tap table: XOR of s[t-1] for each tap t.
  function automatic logic fb(input int n, input logic [15:0] s);
    case (n)
      4:  return s[3] ^ s[2];
      5:  return s[4] ^ s[2];
      6:  return s[5] ^ s[4];
      7:  return s[6] ^ s[5];
      8:  return s[7] ^ s[5] ^ s[4] ^ s[3];
      9:  return s[8] ^ s[4];
      10: return s[9] ^ s[6];
      11: return s[10] ^ s[8];
      12: return s[11] ^ s[5] ^ s[3] ^ s[0];
      13: return s[12] ^ s[3] ^ s[2] ^ s[0];
      14: return s[13] ^ s[4] ^ s[2] ^ s[0];
      15: return s[14] ^ s[13];
      default: return s[15] ^ s[14] ^ s[12] ^ s[3];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run; stop/restart/reset is applied by the caller on the m-th edge after start.
  task automatic run_seq(input int ord, input logic [15:0] seed, input int dv,
                         input logic [15:0] amp, input int m);
    int          n, period, chips;
    int unsigned mask, s;
    chip_t       e;
    n      = (ord < 4) ? 4 : (ord > 16) ? 16 : ord;
    mask   = (32'd1 << n) - 1;
    period = int'(mask);
    s      = seed & mask;
    if (s == 0) s = 1;
    chips  = (m - 1) / (dv + 1) + 1;
    for (int j = 0; j < chips; j++) begin
      e.b   = s[n-1];
      e.ps  = (j % period) == 0;
      e.amp = e.b ? amp : 16'd0;
      e.gap = (j == 0) ? 0 : dv + 1;
      q.push_back(e);
      s = ((s << 1) | 32'(fb(n, 16'(s)))) & mask;
    end
    cfg_order = 5'(ord);
    cfg_seed  = seed;
    cfg_div   = 16'(dv);
    cfg_amp   = amp;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    cfg_order = 5'($urandom);
    cfg_seed  = 16'($urandom);
    cfg_div   = 16'($urandom);
    cfg_amp   = 16'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    repeat (m - 1) tick();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("busy_after_stop", 32'(busy), 32'd0);
    chk("out_after_stop", {sig, mbit, mvalid, mps}, 32'd0);
  endtask

  task automatic do_start_stop();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("busy_start_stop", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    #5;
    rst_n = 1'b0;
    #1;
    chk("busy_async_reset", 32'(busy), 32'd0);
    chk("out_async_reset", {sig, mbit, mvalid, mps}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 32'(busy), 32'd0);
  endtask

  // Monitor
  int          gap_cnt = 0;
  logic [15:0] prev_sig = '0;
  logic        prev_bit = 1'b0;

  always @(negedge clk) begin
    chip_t e;
    if (rst_n) begin
      gap_cnt++;
      if (mvalid) begin
        if (q.size() == 0) begin
          chk("unexpected_chip", 32'(mvalid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("chip_bit", 32'(mbit), 32'(e.b));
          chk("chip_period_start", 32'(mps), 32'(e.ps));
          chk("chip_signal", 32'(sig), 32'(e.amp));
          chk("chip_busy", 32'(busy), 32'd1);
          if (e.gap != 0) chk("chip_gap", 32'(gap_cnt), 32'(e.gap));
        end
        gap_cnt  = 0;
        prev_sig = sig;
        prev_bit = mbit;
      end else if (busy) begin
        chk("hold_signal", {15'd0, mbit, sig}, {15'd0, prev_bit, prev_sig});
        chk("ps_without_valid", 32'(mps), 32'd0);
      end else begin
        chk("idle_out", {sig, mbit, mvalid, mps}, 32'd0);
      end
    end
  end

  initial begin
    int ord, dv, m, kind;
    logic [15:0] seed, amp;
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_order = '0;
    cfg_seed  = '0;
    cfg_div   = '0;
    cfg_amp   = '0;
    repeat (3) tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_out", {sig, mbit, mvalid, mps}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_seq(4, 16'h0001, 0, 16'h0400, 31);
    do_stop();
    run_seq(16, 16'hFFFF, 0, 16'hA5A5, 65537);
    do_stop();
    run_seq(7, 16'h0055, 3, 16'h1234, 509);
    do_stop();
    run_seq(5, 16'h0000, 0, 16'h0F0F, 33);
    do_stop();
    run_seq(20, 16'hBEEF, 1, 16'h7FFF, 20);
    do_stop();
    run_seq(6, 16'h0013, 2, 16'h0000, 9);
    do_stop();
    do_start_stop();
    run_seq(8, 16'h00C3, 1, 16'h8001, 7);
    do_start_stop();
    run_seq(11, 16'h0400, 2, 16'h00FF, 10);
    run_seq(9, 16'h01AA, 0, 16'hFF00, 20);
    do_stop();
    run_seq(9, 16'h0101, 2, 16'hCAFE, 14);
    do_reset();
    run_seq(13, 16'h1ABC, 1, 16'h0042, 25);
    do_stop();

    for (int it = 0; it < 14; it++) begin
      ord  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31))
                                         : int'($urandom_range(4, 16));
      seed = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      dv   = int'($urandom_range(0, 4));
      amp  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      kind = int'($urandom_range(0, 3));
      m    = (kind == 1) ? (dv + 1) * int'($urandom_range(1, 10))
                         : int'($urandom_range(1, 60));
      run_seq(ord, seed, dv, amp, m);
      if (kind <= 1)      do_stop();
      else if (kind == 3) do_reset();
    end
    do_stop();

    repeat (5) tick();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
